// File: rtl/mac_row_drain.sv
// mac_row_drain -- output stage of the 6-column MAC row.
//
// Lines up the staggered column outputs of the row (column i arrives i cycles
// after column 0). Accumulates cfg_passes input-channel passes per column.
// Requantizes each column with round, arithmetic shift and clamp to a QW-bit
// signed value. Presents one result word per job on a valid/ready port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_start           job start, accepted only when idle
//   cfg_passes          passes per job (0 = 2^PW), sampled on accepted start
//   cfg_shift           requantization right shift, sampled on accepted start
//   in_valid, co_in     column-0 beat valid; packed column partial sums
//   out_valid/out_ready result handshake; out_data is packed QW-bit columns
//   busy                job in progress (not idle)
//   done                one-cycle pulse after the result handshake
//   ovf_flag            sticky accumulator overflow, cleared on job start
//   err_drop            sticky dropped-beat flag, cleared on job start
//
// Build option: define DRAIN_RELU_EN to clamp negative results to zero.
module mac_row_drain #(
    parameter int COLUMN = 6,
    parameter int OW     = 17,
    parameter int AW     = 24,
    parameter int QW     = 8,
    parameter int PW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [PW-1:0]        cfg_passes,
    input  logic [4:0]           cfg_shift,
    input  logic                 in_valid,
    input  logic [COLUMN*OW-1:0] co_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLUMN*QW-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf_flag,
    output logic                 err_drop
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;
    state_t state, state_nx;

    // One extra bit so a pass count of 2^PW can be represented.
    logic [PW:0]       passes_q, issued, acc_cnt;
    logic [4:0]        shift_q;
    logic [COLUMN-2:0] vld_pipe;
    logic [COLUMN-1:0] col_ovf;
    logic start_ok, beat_ok, aligned_vld, last_beat, handshake;

    assign start_ok    = cfg_start && (state == S_IDLE);
    assign beat_ok     = in_valid && (state == S_ACC) && (issued < passes_q);
    assign aligned_vld = vld_pipe[COLUMN-2];
    assign last_beat   = aligned_vld && (acc_cnt + (PW+1)'(1) == passes_q);
    assign handshake   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cfg_start) state_nx = S_ACC;
            S_ACC:   if (last_beat) state_nx = S_OUT;
            S_OUT:   if (handshake) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            passes_q  <= '0;
            shift_q   <= '0;
            issued    <= '0;
            acc_cnt   <= '0;
            vld_pipe  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ovf_flag  <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            // Valid runs down the same depth as column 0's data.
            vld_pipe <= (vld_pipe << 1) | (COLUMN-1)'(beat_ok);
            done     <= handshake;
            // Registered one cycle after entering OUT; acc is already stable.
            if (handshake)           out_valid <= 1'b0;
            else if (state == S_OUT) out_valid <= 1'b1;
            if (start_ok) begin
                passes_q <= (cfg_passes == '0) ? {1'b1, {PW{1'b0}}} : {1'b0, cfg_passes};
                shift_q  <= cfg_shift;
                issued   <= '0;
                acc_cnt  <= '0;
                ovf_flag <= 1'b0;
                err_drop <= 1'b0;
            end else begin
                if (beat_ok) issued <= issued + (PW+1)'(1);
                if (aligned_vld) begin
                    acc_cnt <= acc_cnt + (PW+1)'(1);
                    // The first beat loads, so only later adds can overflow.
                    if (acc_cnt != '0 && |col_ovf) ovf_flag <= 1'b1;
                end
            end
            // A beat arriving with a start is still a drop; set wins.
            if (in_valid && !beat_ok) err_drop <= 1'b1;
        end
    end

    localparam logic signed [AW:0] QMAX = (AW+1)'((1 << (QW-1)) - 1);
    localparam logic signed [AW:0] QMIN = ~QMAX;

    for (genvar j = 0; j < COLUMN; j++) begin : g_col
        localparam int DLY = COLUMN - 1 - j;
        logic signed [OW-1:0] psum;
        logic signed [AW-1:0] psum_x, sum, acc;
        logic signed [AW:0]   acc_x, rnd, r, q;

        if (DLY == 0) begin : g_nodly
            assign psum = co_in[j*OW +: OW];
        end else begin : g_dly
            logic [DLY-1:0][OW-1:0] sr;
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else begin
                    sr[0] <= co_in[j*OW +: OW];
                    for (int k = 1; k < DLY; k++) sr[k] <= sr[k-1];
                end
            end
            assign psum = sr[DLY-1];
        end

        assign psum_x     = AW'(psum);
        assign sum        = acc + psum_x;
        assign col_ovf[j] = (acc[AW-1] == psum_x[AW-1]) && (sum[AW-1] != acc[AW-1]);

        always_ff @(posedge clk) begin
            if (rst)              acc <= '0;
            else if (aligned_vld) acc <= (acc_cnt == '0) ? psum_x : sum;
        end

        // Round half up, shift, clamp. AW+1 bits keep acc + 2^(shift-1) exact.
        assign acc_x = (AW+1)'(acc);
        always_comb begin
            rnd = '0;
            if (shift_q != 5'd0 && int'(shift_q) < AW)
                rnd = (AW+1)'(1) << (shift_q - 5'd1);
            if (int'(shift_q) >= AW) r = acc[AW-1] ? '1 : '0;
            else                     r = (acc_x + rnd) >>> shift_q;
            if (r > QMAX)      q = QMAX;
            else if (r < QMIN) q = QMIN;
            else               q = r;
`ifdef DRAIN_RELU_EN
            if (r[AW]) q = '0;
`endif
        end
        assign out_data[j*QW +: QW] = q[QW-1:0];
    end

endmodule

// File: tb/tb_mac_row_drain.sv
module tb_mac_row_drain;
    localparam int COLUMN = 6;
    localparam int OW     = 17;
    localparam int AW     = 24;
    localparam int QW     = 8;
    localparam int PW     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_start, in_valid, out_valid, out_ready, busy, done, ovf_flag, err_drop;
    logic [PW-1:0]        cfg_passes;
    logic [4:0]           cfg_shift;
    logic [COLUMN*OW-1:0] co_in;
    logic [COLUMN*QW-1:0] out_data;

    always #5 clk = ~clk;

    mac_row_drain #(.COLUMN(COLUMN), .OW(OW), .AW(AW), .QW(QW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_passes(cfg_passes),
        .cfg_shift(cfg_shift), .in_valid(in_valid), .co_in(co_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .ovf_flag(ovf_flag), .err_drop(err_drop)
    );

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint last_c0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pv [0:255][0:COLUMN-1];       // psum of pass p, column c
    logic [COLUMN*QW-1:0] exp_data = '0;
    logic exp_ovf = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reduce an exact sum into the signed AW-bit range (two's complement wrap).
    function automatic longint wrap_aw(longint s);
        longint m;
        m = s % (64'sd1 << AW);
        if (m < 0) m += (64'sd1 << AW);
        if (m >= (64'sd1 << (AW-1))) m -= (64'sd1 << AW);
        return m;
    endfunction

    function automatic longint requant(longint a, int sh);
        longint n, d, r;
        if (sh >= AW) r = (a < 0) ? -1 : 0;
        else begin
            d = 64'sd1 << sh;
            n = a + ((sh == 0) ? 0 : d / 2);
            r = n / d;
            if (n < 0 && r * d != n) r = r - 1;   // floor division
        end
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`ifdef DRAIN_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic model_job(input int P, input int sh);
        longint acc, s;
        exp_ovf = 1'b0;
        for (int c = 0; c < COLUMN; c++) begin
            acc = pv[0][c];
            for (int p = 1; p < P; p++) begin
                s = acc + pv[p][c];
                if (s > (64'sd1 << (AW-1)) - 1 || s < -(64'sd1 << (AW-1))) exp_ovf = 1'b1;
                acc = wrap_aw(s);
            end
            exp_data[c*QW +: QW] = QW'(requant(acc, sh));
        end
    endtask

    // Start a job and drive its skewed beats back to back; stop_after >= 0
    // abandons the drive after that many cycles.
    task automatic run_job(input int P, input int sh, input int stop_after);
        int b;
        model_job(P, sh);
        cfg_start = 1'b1; cfg_passes = PW'(P); cfg_shift = 5'(sh);
        tick();
        cfg_start = 1'b0;
        for (int c = 0; c < P + COLUMN - 1; c++) begin
            if (stop_after >= 0 && c == stop_after) break;
            in_valid = (c < P);
            for (int i = 0; i < COLUMN; i++) begin
                b = c - i;
                if (b >= 0 && b < P) co_in[i*OW +: OW] = OW'(pv[b][i]);
                else                 co_in[i*OW +: OW] = OW'($urandom);
            end
            if (c == P - 1) last_c0 = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_latency"}, cyc - last_c0, COLUMN + 1);
        chk({tag, "_ovf"}, ovf_flag, exp_ovf);
    endtask

    task automatic handshake(input string tag);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    // Every cycle: data vs model while valid, hold while stalled, done timing.
    logic prev_ov = 1'b0, prev_or = 1'b0;
    logic [COLUMN*QW-1:0] prev_d = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            chk("done_vs_handshake", done, prev_ov && prev_or);
            if (out_valid) chk("out_data_model", out_data, exp_data);
            if (prev_ov && !prev_or) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_data_hold", out_data, prev_d);
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_d  = out_data;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        cfg_start = 1'b0; cfg_passes = '0; cfg_shift = '0;
        in_valid = 1'b0; co_in = '0; out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf_flag, 0);
        chk("rst_err", err_drop, 0);
        chk("rst_data", out_data, 0);
        tick();
        rst = 1'b0;
        tick();

        // T1: one pass, column i = 10*i.
        for (int i = 0; i < COLUMN; i++) pv[0][i] = 10 * i;
        run_job(1, 0, -1);
        wait_out("t1");
        chk("t1_lit", out_data, 48'h32281E140A00);
        handshake("t1");

        // T2: three passes of 100, shift 2 -> 75.
        for (int p = 0; p < 3; p++) for (int i = 0; i < COLUMN; i++) pv[p][i] = 100;
        run_job(3, 2, -1);
        wait_out("t2");
        chk("t2_lit", out_data, 48'h4B4B4B4B4B4B);
        handshake("t2");

        // T3: clamp both directions.
        for (int i = 0; i < COLUMN; i++) pv[0][i] = 0;
        pv[0][0] = 1000; pv[0][1] = -1000;
        run_job(1, 0, -1);
        wait_out("t3");
`ifdef DRAIN_RELU_EN
        chk("t3_lit", out_data, 48'h00000000007F);
`else
        chk("t3_lit", out_data, 48'h00000000807F);
`endif
        handshake("t3");

        // T4: stall in OUT with a stray beat and an ignored start.
        for (int i = 0; i < COLUMN; i++) pv[0][i] = i + 1;
        run_job(1, 0, -1);
        wait_out("t4");
        in_valid = 1'b1; co_in = {COLUMN{17'h1ABCD}};
        tick();
        in_valid = 1'b0;
        cfg_start = 1'b1; cfg_passes = 8'd7; cfg_shift = 5'd3;
        tick();
        cfg_start = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        chk("t4_err_drop", err_drop, 1);
        chk("t4_busy", busy, 1);
        chk("t4_still_valid", out_valid, 1);
        chk("t4_lit", out_data, 48'h060504030201);
        handshake("t4");
        chk("t4_err_sticky", err_drop, 1);

        // T5: 200 passes of 65535 overflow and wrap; shift 16 exposes the wrap.
        for (int p = 0; p < 200; p++) for (int i = 0; i < COLUMN; i++) pv[p][i] = 65535;
        run_job(200, 16, -1);
        wait_out("t5");
        chk("t5_err_cleared", err_drop, 0);
        chk("t5_ovf_lit", ovf_flag, 1);
`ifdef DRAIN_RELU_EN
        chk("t5_lit", out_data, 48'h000000000000);
`else
        chk("t5_lit", out_data, 48'hC8C8C8C8C8C8);
`endif
        handshake("t5");

        // cfg_passes = 0 means 256 passes.
        for (int p = 0; p < 256; p++) for (int i = 0; i < COLUMN; i++) pv[p][i] = 1;
        run_job(256, 4, -1);
        wait_out("p256");
        chk("p256_lit", out_data, 48'h101010101010);
        handshake("p256");

        // Shift beyond AW: sign only.
        pv[0][0] = -5; pv[0][1] = 5; pv[0][2] = -3; pv[0][3] = 0; pv[0][4] = 7; pv[0][5] = -1;
        run_job(1, 30, -1);
        wait_out("bigshift");
`ifdef DRAIN_RELU_EN
        chk("bigshift_lit", out_data, 48'h000000000000);
`else
        chk("bigshift_lit", out_data, 48'hFF0000FF00FF);
`endif
        handshake("bigshift");

        // T6: reset after 2 of 4 passes, then a clean job.
        for (int p = 0; p < 4; p++) for (int i = 0; i < COLUMN; i++) pv[p][i] = 9;
        run_job(4, 0, 2);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_ovf", ovf_flag, 0);
        chk("t6_err", err_drop, 0);
        chk("t6_data", out_data, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < COLUMN; i++) pv[0][i] = 5;
        run_job(1, 0, -1);
        wait_out("t6b");
        chk("t6b_lit", out_data, 48'h050505050505);
        handshake("t6b");

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
